store_unit: RTL

Store-side counterpart of the load path's sign extension: narrows a 32-bit register value to a byte, halfword or word and steers it onto the correct byte lanes of the data-memory write port with byte enables. It sits between the MEM stage and data memory. It buffers stores in a small FIFO so the pipeline does not stall while memory is busy. Misaligned or illegal store requests are rejected with an error pulse instead of being written.

---
 rtl/store_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// Store path: packs SB/SH/SW data onto byte lanes and buffers writes toward data memory.
// Optional define STORE_ALIGN_CHECK_EN rejects misaligned SH/SW requests.
module store_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             err_valid,
    output logic [31:0]      err_addr,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [29:0]   fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [3:0]    fifo_be   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    logic [31:0] pack_data;
    logic [3:0]  pack_be;
    logic        reject;
    logic        accept;
    logic        push;
    logic        pop;

    // Handshake depends only on occupancy; memory back-pressure never reaches the pipeline directly.
    assign req_ready = (count != FULL_CNT);
    assign mem_valid = (count != '0);
    assign mem_addr  = {fifo_addr[rd_ptr], 2'b00};
    assign mem_wdata = fifo_data[rd_ptr];
    assign mem_be    = fifo_be[rd_ptr];

    assign accept = req_valid && req_ready;
    assign push   = accept && !reject;
    assign pop    = mem_valid && mem_ready;

    always_comb begin
        pack_data = req_data;
        pack_be   = 4'b1111;
        reject    = 1'b0;
        case (req_op)
            2'b00: begin
                pack_data = {4{req_data[7:0]}};
                pack_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                pack_data = {2{req_data[15:0]}};
                pack_be   = req_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_CHECK_EN
                reject    = req_addr[0];
`endif
            end
            2'b10: begin
                pack_data = req_data;
                pack_be   = 4'b1111;
`ifdef STORE_ALIGN_CHECK_EN
                reject    = (req_addr[1:0] != 2'b00);
`endif
            end
            default: begin
                reject    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Entries are only written on push, so the head stays put while memory stalls or the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
                fifo_be[i]   <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            retired   <= '0;
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= req_addr[31:2];
                fifo_data[wr_ptr] <= pack_data;
                fifo_be[wr_ptr]   <= pack_be;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                retired <= retired + CNT_W'(1);
            end
            count     <= count_next;
            busy      <= (count_next != '0);
            err_valid <= accept && reject;
            if (accept && reject) begin
                err_addr <= req_addr;
            end
        end
    end

endmodule
